// File: rtl/barker11_pwm_seq.sv
// barker11_pwm_seq: steps a 4-bit PWM generator through Barker-11 frames.
// Optional inter-frame guard interval: define SEQ_GUARD_EN.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, abort      1-cycle run request (IDLE only) / immediate stop
//   rep_count[3:0]    frames per run, 0 = continuous until abort
//   pos_lo/hi[3:0]    PWM profile for +1 chips
//   neg_lo/hi[3:0]    PWM profile for -1 chips
//   pwm_lo/hi[3:0]    registered low/high time to the PWM generator
//   chip_idx[3:0]     current chip 0..10 (0 outside RUN)
//   chip_val          1 = +1 chip, 0 = -1 chip (0 outside RUN)
//   frame_start       pulse in the first cycle of chip 0 of each frame
//   busy, done        run active / pulse on normal completion
module barker11_pwm_seq #(
    parameter int CHIP_CYCLES  = 64,
    parameter int GUARD_CYCLES = 256,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] rep_count,
    input  logic [3:0] pos_lo,
    input  logic [3:0] pos_hi,
    input  logic [3:0] neg_lo,
    input  logic [3:0] neg_hi,
    output logic [3:0] pwm_lo,
    output logic [3:0] pwm_hi,
    output logic [3:0] chip_idx,
    output logic       chip_val,
    output logic       frame_start,
    output logic       busy,
    output logic       done
);

    // Bit i holds chip i: 1,1,1,0,0,0,1,0,0,1,0
    localparam logic [10:0] CODE = 11'b010_0100_0111;
    localparam logic [CNT_W-1:0] CHIP_LAST = CNT_W'(CHIP_CYCLES - 1);

    if (CHIP_CYCLES < 1 || CHIP_CYCLES > 2**CNT_W - 1 ||
        GUARD_CYCLES < 1 || GUARD_CYCLES > 2**CNT_W - 1) begin : g_bad_param
        $error("barker11_pwm_seq: timer parameter out of range");
    end

`ifdef SEQ_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_GUARD} state_t;
`else
    localparam bit GUARD_EN = 1'b0;
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [3:0]       frames;
    logic [3:0]       cfg_rep;
    logic [3:0]       cfg_pos_lo;
    logic [3:0]       cfg_pos_hi;
    logic [3:0]       cfg_neg_lo;
    logic [3:0]       cfg_neg_hi;

    logic       tick_end;
    logic       last_chip;
    logic       last_frame;
    logic       wrap;
    logic       quit;
    logic       finish;
    logic       load;
    logic [3:0] nc;

    assign tick_end   = timer == CHIP_LAST;
    assign last_chip  = chip_idx == 4'd10;
    assign last_frame = cfg_rep != 4'd0 && frames + 4'd1 == cfg_rep;
    assign wrap       = state == S_RUN && tick_end && last_chip;
    assign quit       = abort && state != S_IDLE;
    assign finish     = wrap && last_frame;
    // Next chip: successor inside a frame, otherwise chip 0 of a new frame
    assign nc = (state == S_RUN && !last_chip) ? chip_idx + 4'd1 : 4'd0;

    always_comb begin
        load = 1'b0;
        if (!quit) begin
            unique case (state)
                S_ARM:   load = 1'b1;
                S_RUN:   load = tick_end && !(last_chip && (last_frame || GUARD_EN));
`ifdef SEQ_GUARD_EN
                S_GUARD: load = timer == GUARD_LAST;
`endif
                default: load = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            frames      <= '0;
            cfg_rep     <= '0;
            cfg_pos_lo  <= '0;
            cfg_pos_hi  <= '0;
            cfg_neg_lo  <= '0;
            cfg_neg_hi  <= '0;
            pwm_lo      <= '0;
            pwm_hi      <= '0;
            chip_idx    <= '0;
            chip_val    <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            done        <= 1'b0;
            if (quit || finish) begin
                // Abort wins over a coinciding normal finish
                state    <= S_IDLE;
                timer    <= '0;
                frames   <= '0;
                pwm_lo   <= '0;
                pwm_hi   <= '0;
                chip_idx <= '0;
                chip_val <= 1'b0;
                busy     <= 1'b0;
                done     <= !quit;
            end else if (load) begin
                state       <= S_RUN;
                timer       <= '0;
                chip_idx    <= nc;
                chip_val    <= CODE[nc];
                {pwm_lo, pwm_hi} <= CODE[nc] ? {cfg_pos_lo, cfg_pos_hi}
                                             : {cfg_neg_lo, cfg_neg_hi};
                frame_start <= nc == 4'd0;
                busy        <= 1'b1;
                if (wrap)
                    frames <= frames + 4'd1;
`ifdef SEQ_GUARD_EN
            end else if (wrap) begin
                state    <= S_GUARD;
                timer    <= '0;
                frames   <= frames + 4'd1;
                pwm_lo   <= '0;
                pwm_hi   <= '0;
                chip_idx <= '0;
                chip_val <= 1'b0;
`endif
            end else if (state == S_IDLE) begin
                if (start && !abort) begin
                    state      <= S_ARM;
                    cfg_rep    <= rep_count;
                    cfg_pos_lo <= pos_lo;
                    cfg_pos_hi <= pos_hi;
                    cfg_neg_lo <= neg_lo;
                    cfg_neg_hi <= neg_hi;
                end
            end else begin
                timer <= timer + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_barker11_pwm_seq.sv
// tb_barker11_pwm_seq: randomized check of barker11_pwm_seq against
// a cycle-index model of the frame/chip schedule.
module tb_barker11_pwm_seq;

    localparam int CC  = 4;
    localparam int GD  = 8;
    localparam int FL  = 11 * CC;
`ifdef SEQ_GUARD_EN
    localparam int GP  = GD;
`else
    localparam int GP  = 0;
`endif
    localparam int PER = FL + GP;

    int code [11] = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] rep_count = '0;
    logic [3:0] pos_lo = '0;
    logic [3:0] pos_hi = '0;
    logic [3:0] neg_lo = '0;
    logic [3:0] neg_hi = '0;
    logic [3:0] pwm_lo;
    logic [3:0] pwm_hi;
    logic [3:0] chip_idx;
    logic       chip_val;
    logic       frame_start;
    logic       busy;
    logic       done;

    int n_chk = 0;
    int n_pass = 0;

    barker11_pwm_seq #(
        .CHIP_CYCLES (CC),
        .GUARD_CYCLES(GD),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .rep_count  (rep_count),
        .pos_lo     (pos_lo),
        .pos_hi     (pos_hi),
        .neg_lo     (neg_lo),
        .neg_hi     (neg_hi),
        .pwm_lo     (pwm_lo),
        .pwm_hi     (pwm_hi),
        .chip_idx   (chip_idx),
        .chip_val   (chip_val),
        .frame_start(frame_start),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    wire [15:0] obs = {pwm_lo, pwm_hi, chip_idx, chip_val,
                       frame_start, busy, done};

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Expected output vector n cycles after the run's first RUN cycle
    function automatic logic [15:0] model(input int n, input int rep,
                                          input logic [3:0] pl, input logic [3:0] ph,
                                          input logic [3:0] nl, input logic [3:0] nh);
        int   total;
        int   k;
        int   c;
        logic v;
        if (rep != 0) begin
            total = rep * FL + (rep - 1) * GP;
            if (n == total) return 16'h0001;
            if (n > total) return 16'h0000;
        end
        k = n % PER;
        if (k >= FL) return 16'h0002;
        c = k / CC;
        v = code[c] != 0;
        return {v ? pl : nl, v ? ph : nh, 4'(c), v, k == 0, 1'b1, 1'b0};
    endfunction

    // stop_n >= 0: abort (or 3-cycle rst) applied on the edge after cycle stop_n-1
    task automatic run(input int rep,
                       input logic [3:0] pl, input logic [3:0] ph,
                       input logic [3:0] nl, input logic [3:0] nh,
                       input int stop_n, input bit use_rst, input bit noise);
        int          total;
        int          last;
        int          lim;
        logic [15:0] e;
        total = (rep != 0) ? rep * FL + (rep - 1) * GP : 1 << 30;
        last  = (stop_n < 0) ? total + 2 : stop_n + 3;
        lim   = (stop_n >= 0 && stop_n < total) ? stop_n : total;
        @(negedge clk);
        rep_count = 4'(rep);
        pos_lo = pl;
        pos_hi = ph;
        neg_lo = nl;
        neg_hi = nh;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("arm", obs, 16'h0000);
        for (int n = 0; n <= last; n++) begin
            abort = !use_rst && n == stop_n;
            rst = use_rst && stop_n >= 0 && n >= stop_n && n < stop_n + 3;
            if (noise && n <= lim) begin
                start = 1'($urandom);
                rep_count = 4'($urandom);
                pos_lo = 4'($urandom);
                pos_hi = 4'($urandom);
                neg_lo = 4'($urandom);
                neg_hi = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (stop_n >= 0 && n >= stop_n)
                e = 16'h0000;
            else
                e = model(n, rep, pl, ph, nl, nh);
            check($sformatf("r%0d_c%0d", rep, n), obs, e);
        end
        abort = 1'b0;
        rst = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int rep;
        int tot;
        int stp;
        repeat (2) @(negedge clk);
        check("reset", obs, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check("idle", obs, 16'h0000);

        run(1, 4'd5, 4'd3, 4'd2, 4'd7, -1, 1'b0, 1'b0);
        run(3, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            -1, 1'b0, 1'b1);
        run(0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            10 * PER + 22, 1'b0, 1'b1);
        run(2, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            30, 1'b1, 1'b1);
        run(1, 4'd0, 4'd9, 4'd6, 4'd0, FL, 1'b0, 1'b0);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("sa_idle0", obs, 16'h0000);
        repeat (2) begin
            @(negedge clk);
            check("sa_idle", obs, 16'h0000);
        end

        for (int i = 0; i < 6; i++) begin
            rep = $urandom_range(1, 4);
            tot = rep * FL + (rep - 1) * GP;
            stp = ($urandom % 3 == 0) ? $urandom_range(1, tot) : -1;
            run(rep, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                stp, 1'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
